// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the register file: round-robin arbitration between the
// ALU (A) and load (B) writeback paths, plus a zero-fill sequence after reset or on demand.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    input  logic                  CLEAR_REQ,
    output logic                  BUSY,
    output logic                  WRITE,
    output logic [ADDR_WIDTH-1:0] INADDRESS,
    output logic [DATA_WIDTH-1:0] IN
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                    last_reg, last_next;
    logic                    write_reg, write_next;
    logic [ADDR_WIDTH-1:0]   inaddress_reg, inaddress_next;
    logic [DATA_WIDTH-1:0]   in_reg, in_next;

    logic grant_a, grant_b;
    logic in_run;

    // With both valid, the requester that did not win last time gets the port.
    assign grant_a = A_VALID && (!B_VALID || (last_reg == LAST_B));
    assign grant_b = B_VALID && (!A_VALID || (last_reg == LAST_A));
    assign in_run  = (state_reg == ST_RUN);

    assign A_READY   = in_run && grant_a && !CLEAR_REQ;
    assign B_READY   = in_run && grant_b && !CLEAR_REQ;
    assign BUSY      = !in_run;
    assign WRITE     = write_reg;
    assign INADDRESS = inaddress_reg;
    assign IN        = in_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        write_next     = 1'b0;
        inaddress_next = inaddress_reg;
        in_next        = in_reg;
        case (state_reg)
            ST_CLEAR: begin
                write_next     = 1'b1;
                inaddress_next = cnt_reg;
                in_next        = '0;
                cnt_next       = cnt_reg + ADDR_WIDTH'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                if (CLEAR_REQ) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end else if (A_VALID && A_READY) begin
                    write_next     = 1'b1;
                    inaddress_next = A_ADDR;
                    in_next        = A_DATA;
                    last_next      = LAST_A;
                end else if (B_VALID && B_READY) begin
                    write_next     = 1'b1;
                    inaddress_next = B_ADDR;
                    in_next        = B_DATA;
                    last_next      = LAST_B;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg     <= ST_CLEAR;
            cnt_reg       <= '0;
            last_reg      <= LAST_B;
            write_reg     <= 1'b0;
            inaddress_reg <= '0;
            in_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            write_reg     <= write_next;
            inaddress_reg <= inaddress_next;
            in_reg        <= in_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: expected register-file writes are queued
// when stimulus is driven and compared in order as WRITE pulses appear.
module tb_regfile_write_arbiter;

    logic       CLK;
    logic       RESET;
    logic       A_VALID, B_VALID, CLEAR_REQ;
    logic [2:0] A_ADDR, B_ADDR;
    logic [7:0] A_DATA, B_DATA;
    logic       A_READY, B_READY, BUSY, WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;

    int checks_count = 0;
    int errors_count = 0;

    logic [10:0] exp_q[$];
    logic [7:0]  regs_model[8];

    regfile_write_arbiter #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .NUM_REGS  (8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .A_VALID  (A_VALID),
        .A_ADDR   (A_ADDR),
        .A_DATA   (A_DATA),
        .A_READY  (A_READY),
        .B_VALID  (B_VALID),
        .B_ADDR   (B_ADDR),
        .B_DATA   (B_DATA),
        .B_READY  (B_READY),
        .CLEAR_REQ(CLEAR_REQ),
        .BUSY     (BUSY),
        .WRITE    (WRITE),
        .INADDRESS(INADDRESS),
        .IN       (IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_count++;
        if (got !== exp) begin
            errors_count++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Register-file model captures the write one edge after the handshake.
    always @(posedge CLK) begin
        if (WRITE === 1'b1) regs_model[INADDRESS] <= IN;
    end

    // Scoreboard: every WRITE pulse must match the next queued {addr,data}.
    always @(negedge CLK) begin
        if (WRITE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_write", {21'd0, INADDRESS, IN}, 32'h7FF);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check_value("write_addr_data", {21'd0, INADDRESS, IN}, {21'd0, e});
                $display("write addr=%0d data=%02h", INADDRESS, IN);
            end
        end
    end

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({3'(i), 8'h00});
    endtask

    // Called at a negedge: drive one cycle, check the combinational readies, queue any
    // expected transfer, then advance to the next negedge.
    task automatic drive_cycle(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                               input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                               input logic exp_ar, input logic exp_br);
        A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
        #1;
        check_value("a_ready", {31'd0, A_READY}, {31'd0, exp_ar});
        check_value("b_ready", {31'd0, B_READY}, {31'd0, exp_br});
        if (exp_ar) exp_q.push_back({aa, ad});
        else if (exp_br) exp_q.push_back({ba, bd});
        $display("cycle a_v=%0b b_v=%0b a_ready=%0b b_ready=%0b", av, bv, A_READY, B_READY);
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0; CLEAR_REQ = 1'b0;
        A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
        B_VALID = 1'b0; B_ADDR = '0; B_DATA = '0;
        for (int i = 0; i < 8; i++) regs_model[i] = 8'hxx;

        // Reset and power-up clear
        repeat (2) @(negedge CLK);
        check_value("rst_busy", {31'd0, BUSY}, 32'd1);
        check_value("rst_a_ready", {31'd0, A_READY}, 32'd0);
        check_value("rst_b_ready", {31'd0, B_READY}, 32'd0);
        check_value("rst_write", {31'd0, WRITE}, 32'd0);
        check_value("rst_inaddress", {29'd0, INADDRESS}, 32'd0);
        check_value("rst_in", {24'd0, IN}, 32'd0);
        push_clear(8);
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check_value("clr_write", {31'd0, WRITE}, 32'd1);
            check_value("clr_busy", {31'd0, BUSY}, (i < 7) ? 32'd1 : 32'd0);
        end

        // Single requester on the first RUN cycle
        drive_cycle(1'b1, 3'd2, 8'h06, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        A_VALID = 1'b0;
        check_value("single_write", {31'd0, WRITE}, 32'd1);
        @(negedge CLK);
        check_value("single_idle_write", {31'd0, WRITE}, 32'd0);
        check_value("single_hold_in", {24'd0, IN}, 32'h06);

        // Make B the last winner, then contend on the same address
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h55, 1'b0, 1'b1);
        drive_cycle(1'b1, 3'd3, 8'hE6, 1'b1, 3'd3, 8'h11, 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h11, 1'b0, 1'b1);
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        check_value("same_addr_survivor", {24'd0, regs_model[3]}, 32'h11);

        // Fairness: both valid for six cycles alternates A, B, A, B, ...
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 3'(i), 8'hA0 + 8'(i), 1'b1, 3'(7 - i), 8'hB0 + 8'(i),
                        (i % 2) == 0, (i % 2) == 1);
        end
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

        // CLEAR_REQ collides with a pending A write
        A_VALID = 1'b1; A_ADDR = 3'd5; A_DATA = 8'h5A; CLEAR_REQ = 1'b1;
        #1;
        check_value("clrreq_a_ready", {31'd0, A_READY}, 32'd0);
        check_value("clrreq_b_ready", {31'd0, B_READY}, 32'd0);
        push_clear(8);
        @(negedge CLK);
        CLEAR_REQ = 1'b0;
        check_value("clrreq_write", {31'd0, WRITE}, 32'd0);
        check_value("clrreq_busy", {31'd0, BUSY}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_value("clrreq_a_blocked", {31'd0, A_READY}, 32'd0);
            @(negedge CLK);
            check_value("clrreq_fill_write", {31'd0, WRITE}, 32'd1);
        end
        drive_cycle(1'b1, 3'd5, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        A_VALID = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a clear sequence
        CLEAR_REQ = 1'b1;
        push_clear(4);
        @(negedge CLK);
        CLEAR_REQ = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_value("midrst_write", {31'd0, WRITE}, 32'd0);
        check_value("midrst_inaddress", {29'd0, INADDRESS}, 32'd0);
        check_value("midrst_busy", {31'd0, BUSY}, 32'd1);
        RESET = 1'b1;
        push_clear(8);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check_value("restart_write", {31'd0, WRITE}, 32'd1);
        end
        check_value("restart_busy", {31'd0, BUSY}, 32'd0);
        repeat (2) @(negedge CLK);
        check_value("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port controller for the 8×8 register file. It shares the file's single write port (WRITE/INADDRESS/IN) between two requesters, the ALU writeback path (A) and the load writeback path (B), using valid/ready handshakes and round-robin priority. It also runs an 8-cycle zero-fill sequence through the write port after reset and on demand. It sits between the datapath writeback sources and the register file's write inputs; read ports are not touched.

## Interface
Parameters:
- DATA_WIDTH, 8, width of register data
- ADDR_WIDTH, 3, register address width
- NUM_REGS, 8, registers to clear; must equal 2**ADDR_WIDTH

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  one clock; reset is synchronous and active-low
- A_VALID  in  1  requester A (ALU) has a write pending
- A_ADDR  in  ADDR_WIDTH  destination register for A
- A_DATA  in  DATA_WIDTH  write data for A
- A_READY  out  1  A's write is accepted this cycle
- B_VALID  in  1  requester B (load) has a write pending
- B_ADDR  in  ADDR_WIDTH  destination register for B
- B_DATA  in  DATA_WIDTH  write data for B
- B_READY  out  1  B's write is accepted this cycle
- CLEAR_REQ  in  1  single-cycle pulse that starts a zero-fill sequence
- BUSY  out  1  high while the zero-fill sequence is running
- WRITE  out  1  register-file write enable (registered)
- INADDRESS  out  ADDR_WIDTH  register-file write address (registered)
- IN  out  DATA_WIDTH  register-file write data (registered)

## Operation
- States are CLEAR and RUN, plus a round-robin pointer `last` (A or B) and a clear counter `cnt` of width ADDR_WIDTH.
- **Reset (RESET=0 at a posedge):**
  - state=CLEAR, cnt=0, last=B, so A wins first.
  - WRITE=0, INADDRESS=0, IN=0.
- **Ready outputs during reset:** A_READY, B_READY and BUSY are combinational from state, so they read 0, 0, 1 while RESET is low.
- **CLEAR state:**
  - Each cycle, register WRITE=1, INADDRESS=cnt, IN=0, then increment cnt.
  - When cnt==NUM_REGS-1 is issued, go to RUN next cycle.
  - BUSY=1 and both READYs are 0 throughout.
- **RUN state:**
  - BUSY=0.
  - Grant rule:
    - Only A valid: A is granted.
    - Only B valid: B is granted.
    - Both valid: the requester other than `last` is granted.
  - Combinational READY: x_READY=1 iff x is granted and CLEAR_REQ=0.
  - Transfer: on VALID&&READY at a posedge, register WRITE=1, INADDRESS=x_ADDR, IN=x_DATA, and set last=x.
  - No transfer: WRITE=0; INADDRESS and IN hold their values.
- **CLEAR_REQ in RUN:**
  - Both READYs are forced low that cycle and no transfer occurs.
  - Next state is CLEAR with cnt=0 and WRITE=0 that cycle.
  - CLEAR_REQ is ignored while already in CLEAR.
- **Requester rules:**
  - A requester must hold VALID, ADDR and DATA stable until accepted.
  - The losing requester is accepted on the next cycle if it stays valid.
- **Same address from both:** no merging. The writes are performed in grant order, so the later grant's data survives in the register file.
- **Reset mid-sequence:** a RESET low in any state, including mid-CLEAR, restarts the behaviour from the reset values above. A write transfer in flight is dropped.

## Timing
- Latency: a handshake at posedge N gives WRITE/INADDRESS/IN valid after posedge N. The register file captures the write at posedge N+1.
- Throughput: one write per cycle; with both requesters continuously valid, grants alternate A, B, A, B.
- Clear sequence:
  - After RESET is deasserted, WRITE=1 for exactly NUM_REGS consecutive cycles with addresses 0..7 and IN=0.
  - The first RUN cycle (earliest handshake) is cycle NUM_REGS+1 after deassertion, counting the first CLEAR cycle as cycle 1.
- No combinational path from VALID inputs to WRITE/INADDRESS/IN. The only combinational input-to-output paths are VALID/CLEAR_REQ/state to READY.

## Test plan
- **Reset/clear:** hold RESET=0 for 2 cycles, then release -> WRITE=1 with INADDRESS=0..7 and IN=0 on 8 consecutive cycles, BUSY=1 throughout, then BUSY=0 and WRITE=0.
- **Single requester:** A_VALID=1, A_ADDR=2, A_DATA=8'h06 for one cycle in RUN -> A_READY=1 that cycle; next cycle WRITE=1, INADDRESS=2, IN=8'h06; following cycle WRITE=0.
- **Contention:**
  - Setup: last=B; A holds addr 3 / 8'hE6, B holds addr 3 / 8'h11, both valid.
  - Cycle 1: A granted -> WRITE cycle with IN=8'hE6.
  - Cycle 2: B granted -> WRITE cycle with IN=8'h11.
  - A register-file read of addr 3 afterwards returns 8'h11.
- **Fairness:** A and B both valid for 6 cycles -> grant order A, B, A, B, A, B with no idle cycles.
- **CLEAR_REQ collision:** pulse CLEAR_REQ while A_VALID=1 -> A_READY=0 that cycle, then 8 zero writes with BUSY=1. A is accepted on the first RUN cycle and its write appears after the zero-fill.
- **Reset mid-clear:** drive RESET=0 at CLEAR cnt=4 -> WRITE=0 and INADDRESS=0 next cycle; the sequence restarts at address 0 after release.
